one_wire_master: RTL and testbench

- Parametrised successor to the write-only 1-Wire transmitter: a full 1-Wire bus master.
- Executes queued commands over a valid/ready interface: bus reset with presence detect, write byte, read byte, write single bit, read single bit.
- Timing is derived from CLK_MHZ and per-phase microsecond parameters.
- Sits between the host-side sequencer (ROM/function command engine) and the open-drain one_wire_data pad.

---
 rtl/one_wire_master.sv | 155 +++++++++++++++
 tb/tb_one_wire_master.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/one_wire_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : one_wire_master                                              |
// | Description : 1-Wire bus master. Executes bus reset with presence detect,  |
// |               byte/bit write and byte/bit read commands received over a    |
// |               valid/ready interface, drives the open-drain bus low only.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module one_wire_master #(
   parameter int unsigned CLK_MHZ   = 100,
   parameter int unsigned T_RSTL_US = 480,
   parameter int unsigned T_RSTH_US = 480,
   parameter int unsigned T_PDS_US  = 70,
   parameter int unsigned T_SLOT_US = 60,
   parameter int unsigned T_REC_US  = 1,
   parameter int unsigned T_W1L_US  = 6,
   parameter int unsigned T_W0L_US  = 60,
   parameter int unsigned T_RL_US   = 2,
   parameter int unsigned T_MSR_US  = 13,
   parameter int unsigned CNT_W     = 20
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [2:0] cmd_op,
   input  logic [7:0] cmd_data,
   output logic       rsp_valid,
   output logic [7:0] rsp_data,
   output logic       rsp_presence,
   output logic       busy,
   inout  wire        one_wire_data
);

   // Phase lengths expressed as "last counter value" (length - 1), except the
   // two sample points which are absolute counter values.
   localparam logic [CNT_W-1:0] c_RSTL_M1 = CNT_W'(T_RSTL_US * CLK_MHZ - 1);
   localparam logic [CNT_W-1:0] c_RSTH_M1 = CNT_W'(T_RSTH_US * CLK_MHZ - 1);
   localparam logic [CNT_W-1:0] c_PDS     = CNT_W'(T_PDS_US * CLK_MHZ);
   localparam logic [CNT_W-1:0] c_SLOT_M1 = CNT_W'(T_SLOT_US * CLK_MHZ - 1);
   localparam logic [CNT_W-1:0] c_REC_M1  = CNT_W'(T_REC_US * CLK_MHZ - 1);
   localparam logic [CNT_W-1:0] c_W1L_M1  = CNT_W'(T_W1L_US * CLK_MHZ - 1);
   localparam logic [CNT_W-1:0] c_W0L_M1  = CNT_W'(T_W0L_US * CLK_MHZ - 1);
   localparam logic [CNT_W-1:0] c_RL_M1   = CNT_W'(T_RL_US * CLK_MHZ - 1);
   localparam logic [CNT_W-1:0] c_MSR     = CNT_W'(T_MSR_US * CLK_MHZ);
   localparam logic [CNT_W-1:0] c_ONE     = CNT_W'(1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_RST_LOW   = 3'd1,
      S_RST_HIGH  = 3'd2,
      S_SLOT_LOW  = 3'd3,
      S_SLOT_HIGH = 3'd4,
      S_RECOVER   = 3'd5,
      S_DONE      = 3'd6
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [CNT_W-1:0] r_cnt;
   logic [2:0]       r_op;
   logic [7:0]       r_wdata;
   logic [7:0]       r_rdata;
   logic [2:0]       r_bit_idx;
   logic             r_presence;
   logic             r_drive;
   logic [1:0]       r_sync;
   logic             w_sync;
   logic             w_is_read;
   logic             w_last_bit;
   logic [CNT_W-1:0] w_low_m1;

   assign w_sync     = r_sync[1];
   assign w_is_read  = (r_op == 3'd2) || (r_op == 3'd4);
   assign w_last_bit = (r_op == 3'd3) || (r_op == 3'd4) || (r_bit_idx == 3'd7);
   assign w_low_m1   = w_is_read ? c_RL_M1 : (r_wdata[r_bit_idx] ? c_W1L_M1 : c_W0L_M1);

   // Open-drain pad: only ever pulled low, from a registered enable.
   assign one_wire_data = r_drive ? 1'b0 : 1'bz;

   assign cmd_ready    = (r_state == S_IDLE);
   assign busy         = (r_state != S_IDLE) && (r_state != S_DONE);
   assign rsp_valid    = (r_state == S_DONE);
   assign rsp_data     = r_rdata;
   assign rsp_presence = r_presence;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // Next-state decode driven by the per-state cycle counter.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (cmd_valid) begin
               case (cmd_op)
                  3'd0:                      w_next = S_RST_LOW;
                  3'd1, 3'd2, 3'd3, 3'd4:    w_next = S_SLOT_LOW;
                  default:                   w_next = S_DONE;
               endcase
            end
         end
         S_RST_LOW:   if (r_cnt == c_RSTL_M1) w_next = S_RST_HIGH;
         S_RST_HIGH:  if (r_cnt == c_RSTH_M1) w_next = S_DONE;
         // A low phase that fills the whole slot skips the released phase.
         S_SLOT_LOW:  if (r_cnt == w_low_m1)
                         w_next = (w_low_m1 >= c_SLOT_M1) ? S_RECOVER : S_SLOT_HIGH;
         S_SLOT_HIGH: if (r_cnt >= c_SLOT_M1) w_next = S_RECOVER;
         S_RECOVER:   if (r_cnt == c_REC_M1)
                         w_next = w_last_bit ? S_DONE : S_SLOT_LOW;
         S_DONE:      w_next = S_IDLE;
         default:     w_next = S_IDLE;
      endcase
   end

   // Datapath: timing counter, command latch, bit shifting, sampling, bus drive.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt      <= '0;
         r_op       <= 3'd0;
         r_wdata    <= 8'd0;
         r_rdata    <= 8'd0;
         r_bit_idx  <= 3'd0;
         r_presence <= 1'b0;
         r_drive    <= 1'b0;
         r_sync     <= 2'b11;
      end else begin
         r_sync  <= {r_sync[0], one_wire_data};
         // The slot counter keeps running from SLOT_LOW into SLOT_HIGH.
         if ((w_next != r_state) &&
             !((r_state == S_SLOT_LOW) && (w_next == S_SLOT_HIGH)))
            r_cnt <= '0;
         else
            r_cnt <= r_cnt + c_ONE;
         r_drive <= (w_next == S_RST_LOW) || (w_next == S_SLOT_LOW);
         if ((r_state == S_IDLE) && cmd_valid) begin
            r_op      <= cmd_op;
            r_wdata   <= cmd_data;
            r_rdata   <= 8'd0;
            r_bit_idx <= 3'd0;
         end
         if ((r_state == S_RST_HIGH) && (r_cnt == c_PDS))
            r_presence <= ~w_sync;
         if ((r_state == S_SLOT_HIGH) && (r_cnt == c_MSR) && w_is_read)
            r_rdata[r_bit_idx] <= w_sync;
         if ((r_state == S_RECOVER) && (w_next == S_SLOT_LOW))
            r_bit_idx <= r_bit_idx + 3'd1;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_one_wire_master.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_one_wire_master                                           |
// | Description : Self-checking bench for one_wire_master with a slave model,  |
// |               bus-level low-pulse monitor and a timing reference model.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_one_wire_master;

   localparam int CLK_MHZ   = 2;
   localparam int C_RSTL    = 480 * CLK_MHZ;
   localparam int C_RSTH    = 480 * CLK_MHZ;
   localparam int C_SLOT    = 60 * CLK_MHZ;
   localparam int C_REC     = 1 * CLK_MHZ;
   localparam int C_W1L     = 6 * CLK_MHZ;
   localparam int C_W0L     = 60 * CLK_MHZ;
   localparam int C_RL      = 2 * CLK_MHZ;
   localparam int SLAVE_HLD = 39;   // read-0 pull: bus low SLAVE_HLD+1 cycles
   localparam int PRES_DLY  = 60;   // presence pull starts 30 us after release
   localparam int PRES_HLD  = 200;  // presence pull lasts 100 us

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [2:0] cmd_op = 3'd0;
   logic [7:0] cmd_data = 8'd0;
   logic       rsp_valid;
   logic [7:0] rsp_data;
   logic       rsp_presence;
   logic       busy;
   wire        one_wire_data;

   logic       slave_low = 1'b0;
   assign one_wire_data = slave_low ? 1'b0 : 1'bz;
   pullup (one_wire_data);

   one_wire_master #(.CLK_MHZ(CLK_MHZ)) dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_data(cmd_data), .rsp_valid(rsp_valid),
      .rsp_data(rsp_data), .rsp_presence(rsp_presence), .busy(busy),
      .one_wire_data(one_wire_data)
   );

   always #5 clk = ~clk;

   int   checks = 0;
   int   errors = 0;
   bit   m_pres = 1'b0;

   // Slave control, written only by the stimulus process.
   bit         read_mode = 1'b0;
   bit         pres_en = 1'b0;
   logic [7:0] rd_bits = 8'd0;

   // Monitor state, written only by the monitor/slave process.
   int   q_low[$];
   int   low_run = 0;
   int   last_low = 0;
   int   rd_idx = 0;
   int   s_hold = 0;
   int   s_delay = 0;
   logic prev_bus = 1'b1;

   // Bus monitor (low-pulse widths) followed by the slave reaction.
   always @(negedge clk) begin
      logic b;
      b = one_wire_data;
      if (b == 1'b0) low_run++;
      else if (low_run > 0) begin
         q_low.push_back(low_run);
         last_low = low_run;
         low_run  = 0;
      end
      if (!read_mode) rd_idx = 0;
      if (s_hold > 0) begin
         s_hold--;
         if (s_hold == 0) slave_low = 1'b0;
      end
      if (s_delay > 0) begin
         s_delay--;
         if (s_delay == 0) begin
            slave_low = 1'b1;
            s_hold    = PRES_HLD;
         end
      end
      if (b == 1'b0 && prev_bus == 1'b1 && !slave_low && read_mode) begin
         if (rd_idx < 8 && rd_bits[rd_idx] == 1'b0) begin
            slave_low = 1'b1;
            s_hold    = SLAVE_HLD;
         end
         rd_idx++;
      end
      if (b == 1'b1 && prev_bus == 1'b0 && last_low >= 900 && pres_en)
         s_delay = PRES_DLY;
      prev_bus = b;
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference model: expected rsp_data from the op and slave bit pattern.
   function automatic logic [7:0] model_data(input logic [2:0] op, input logic [7:0] rdb);
      if (op == 3'd2) return rdb;
      if (op == 3'd4) return {7'd0, rdb[0]};
      return 8'd0;
   endfunction

   task automatic run_cmd(input logic [2:0] op, input logic [7:0] data,
                          input logic [7:0] rdb, input bit pres,
                          input logic [7:0] exp_data);
      int  exp_w[$];
      int  exp_lat;
      int  nb;
      int  n;
      int  base;
      bit  got;
      nb = (op == 3'd1 || op == 3'd2) ? 8 : 1;
      if (op == 3'd0) begin
         exp_w.push_back(C_RSTL);
         if (pres) exp_w.push_back(PRES_HLD);
         exp_lat = 1 + C_RSTL + C_RSTH;
         m_pres  = pres;
      end else if (op <= 3'd4) begin
         for (int i = 0; i < nb; i++) begin
            if (op == 3'd1 || op == 3'd3)
               exp_w.push_back(data[i] ? C_W1L : ((C_W0L < C_SLOT) ? C_W0L : C_SLOT));
            else
               exp_w.push_back(rdb[i] ? C_RL : SLAVE_HLD + 1);
         end
         exp_lat = 1 + nb * (C_SLOT + C_REC);
      end else begin
         exp_lat = 1;
      end

      read_mode = 1'b0;
      @(negedge clk);
      @(negedge clk);
      read_mode = (op == 3'd2 || op == 3'd4);
      pres_en   = pres;
      rd_bits   = rdb;
      base      = q_low.size();
      chk("ready_before_cmd", int'(cmd_ready), 1);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_data  = data;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      n   = 0;
      got = 1'b0;
      while (n < 5000 && !got) begin
         @(negedge clk);
         n++;
         if (n == 1 && op <= 3'd4) begin
            chk("busy_after_accept", int'(busy), 1);
            chk("ready_while_busy", int'(cmd_ready), 0);
         end
         if (rsp_valid) got = 1'b1;
      end
      chk("rsp_seen", int'(got), 1);
      chk("latency", n, exp_lat);
      chk("rsp_data", int'(rsp_data), int'(exp_data));
      chk("busy_at_rsp", int'(busy), 0);
      chk("presence", int'(rsp_presence), int'(m_pres));
      @(negedge clk);
      chk("rsp_one_cycle", int'(rsp_valid), 0);
      chk("low_count", q_low.size() - base, exp_w.size());
      for (int i = 0; i < exp_w.size() && base + i < q_low.size(); i++)
         chk("low_width", q_low[base + i], exp_w[i]);
   endtask

   typedef struct {
      logic [2:0] op;
      logic [7:0] data;
      logic [7:0] rdb;
      bit         pres;
      logic [7:0] exp_data;
   } vec_t;

   vec_t vecs[$];

   initial begin
      int nrsp;
      vecs.push_back('{3'd0, 8'h00, 8'hFF, 1'b1, 8'h00});  // reset, slave present
      vecs.push_back('{3'd0, 8'h00, 8'hFF, 1'b0, 8'h00});  // reset, no slave
      vecs.push_back('{3'd1, 8'hA5, 8'hFF, 1'b0, 8'h00});  // write byte
      vecs.push_back('{3'd2, 8'h00, 8'hB5, 1'b0, 8'hB5});  // read byte, bits 1,3,6 low
      vecs.push_back('{3'd3, 8'h01, 8'hFF, 1'b0, 8'h00});  // write bit 1
      vecs.push_back('{3'd3, 8'hFE, 8'hFF, 1'b0, 8'h00});  // write bit 0
      vecs.push_back('{3'd4, 8'h00, 8'hFF, 1'b0, 8'h01});  // read bit, bus idle high
      vecs.push_back('{3'd4, 8'h00, 8'h00, 1'b0, 8'h00});  // read bit, slave pulls 0
      vecs.push_back('{3'd5, 8'hFF, 8'hFF, 1'b0, 8'h00});  // reserved
      vecs.push_back('{3'd7, 8'h3C, 8'hFF, 1'b0, 8'h00});  // reserved

      // Reset state.
      repeat (3) @(negedge clk);
      chk("rst_bus_released", int'(one_wire_data), 1);
      chk("rst_cmd_ready", int'(cmd_ready), 1);
      chk("rst_busy", int'(busy), 0);
      chk("rst_rsp_valid", int'(rsp_valid), 0);
      chk("rst_rsp_data", int'(rsp_data), 0);
      chk("rst_presence", int'(rsp_presence), 0);
      rst_n = 1'b1;

      foreach (vecs[i])
         run_cmd(vecs[i].op, vecs[i].data, vecs[i].rdb, vecs[i].pres, vecs[i].exp_data);

      // Randomised commands against the reference model.
      for (int k = 0; k < 10; k++) begin
         logic [2:0] op;
         logic [7:0] d;
         logic [7:0] r;
         bit         p;
         op = 3'($urandom_range(0, 7));
         d  = 8'($urandom);
         r  = 8'($urandom);
         p  = 1'($urandom_range(0, 1));
         run_cmd(op, d, r, p, model_data(op, r));
      end

      // Asynchronous reset during the low phase of bit 3 of a byte read.
      read_mode = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rd_bits   = 8'hFF;
      read_mode = 1'b1;
      cmd_valid = 1'b1;
      cmd_op    = 3'd2;
      cmd_data  = 8'h00;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      repeat (3 * (C_SLOT + C_REC) + 2) @(negedge clk);
      chk("mid_bit3_low", int'(one_wire_data), 0);
      #1 rst_n = 1'b0;
      #1;
      chk("mid_rst_bus_released", int'(one_wire_data), 1);
      chk("mid_rst_ready", int'(cmd_ready), 1);
      chk("mid_rst_busy", int'(busy), 0);
      m_pres = 1'b0;
      nrsp   = 0;
      repeat (3) begin
         @(negedge clk);
         if (rsp_valid) nrsp++;
      end
      rst_n = 1'b1;
      repeat (5) begin
         @(negedge clk);
         if (rsp_valid) nrsp++;
      end
      chk("mid_rst_no_rsp", nrsp, 0);
      run_cmd(3'd1, 8'h3C, 8'hFF, 1'b0, 8'h00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
